// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package elastic_pipe_pkg;

  // Each stage holds a main word plus one skid word.
  localparam int CAPACITY_PER_STAGE = 2;

  // Bits needed to count 0..CAPACITY_PER_STAGE*stages inclusive.
  function automatic int occ_width(int stages);
    return $clog2(CAPACITY_PER_STAGE * stages + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Handshake bundle of the elastic pipeline: upstream, downstream, flush, occupancy.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry it; master drives requests, slave is the pipe.
interface elastic_pipe_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_STAGES = 3
);
  import elastic_pipe_pkg::*;

  localparam int OCC_W = occ_width(NUM_STAGES);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/elastic_pipe_skid_stage.sv
// One elastic stage: main register plus a skid register so ready is fully registered.
// Latency: 1 cycle from up-fire to dn_valid when the stage is empty.
// Backpressure: up_ready = ~s_valid; drops the cycle after a word parks in skid.
module skid_stage
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             m_valid;
  logic             s_valid;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] s_data;
  logic             up_fire;
  logic             dn_fire;

  assign up_ready = ~s_valid;
  assign dn_valid = m_valid;
  assign dn_data  = m_data;
  assign up_fire  = up_valid & up_ready;
  assign dn_fire  = m_valid & dn_ready;

  // Main/skid update: skid always refills main first, so order is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      // Drop contents but leave data registers untouched.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      // Skid occupied: no up-fire possible; drain skid into main on dn-fire.
      if (dn_fire) begin
        m_data  <= s_data;
        s_valid <= 1'b0;
      end
    end else if (up_fire) begin
      if (!m_valid || dn_fire) begin
        m_data  <= up_data;
        m_valid <= 1'b1;
      end else begin
        s_data  <= up_data;
        s_valid <= 1'b1;
      end
    end else if (dn_fire) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic pipeline of NUM_STAGES skid stages with flush and occupancy count.
// Latency: NUM_STAGES cycles from in-fire to out_valid in an empty pipe.
// Backpressure: registered in_ready; holds 2*NUM_STAGES words; flush masks both handshakes.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_STAGES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  elastic_pipe_if.slave bus
);

  localparam int OCC_W = occ_width(NUM_STAGES);

  logic [NUM_STAGES:0] vld;
  logic [NUM_STAGES:0] rdy;
  logic [WIDTH-1:0]    dat [NUM_STAGES+1];
  logic                in_fire;
  logic                out_fire;
  logic [OCC_W-1:0]    occ_q;

  // Flush gates the external handshakes so no word moves in that cycle.
  assign vld[0]          = bus.in_valid & ~bus.flush;
  assign dat[0]          = bus.in_data;
  assign rdy[NUM_STAGES] = bus.out_ready & ~bus.flush;

  assign bus.in_ready  = rdy[0] & ~bus.flush;
  assign bus.out_valid = vld[NUM_STAGES] & ~bus.flush;
  assign bus.out_data  = dat[NUM_STAGES];
  assign bus.occupancy = occ_q;

  assign in_fire  = vld[0] & rdy[0];
  assign out_fire = vld[NUM_STAGES] & rdy[NUM_STAGES];

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    skid_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush),
      .up_valid (vld[i]),
      .up_ready (rdy[i]),
      .up_data  (dat[i]),
      .dn_valid (vld[i+1]),
      .dn_ready (rdy[i+1]),
      .dn_data  (dat[i+1])
    );
  end

  // Word count: +1 per accepted word, -1 per delivered word, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (bus.flush) begin
      occ_q <= '0;
    end else if (in_fire && !out_fire) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (!in_fire && out_fire) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed and scoreboard checks of elastic_pipe in three configurations.
// Latency: n/a (testbench).
// Backpressure: stimulus drives out_ready patterns directly.
module tb_elastic_pipe;

  logic clk;
  logic rst_n;

  elastic_pipe_if #(.WIDTH(8),  .NUM_STAGES(3)) bus_a ();
  elastic_pipe_if #(.WIDTH(32), .NUM_STAGES(5)) bus_b ();
  elastic_pipe_if #(.WIDTH(8),  .NUM_STAGES(1)) bus_c ();

  elastic_pipe #(.WIDTH(8),  .NUM_STAGES(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  elastic_pipe #(.WIDTH(32), .NUM_STAGES(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  elastic_pipe #(.WIDTH(8),  .NUM_STAGES(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(logic fl, logic iv, logic [7:0] d, logic ordy,
                              logic ir, logic ov, logic [7:0] od, logic [2:0] occ);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_occ = occ;
    return v;
  endfunction

  task automatic idle_all();
    bus_a.flush = 0; bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0;
    bus_b.flush = 0; bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.out_ready = 0;
    bus_c.flush = 0; bus_c.in_valid = 0; bus_c.in_data = '0; bus_c.out_ready = 0;
  endtask

  logic [31:0] q_b [$];
  logic [7:0]  q_c [$];
  logic [7:0]  nxt;
  int          exp_occ;

  initial begin
    // Fill to capacity, drain, refill, flush while full, then 0xAA comes out first.
    //            fl iv d      ordy ir ov od     occ
    tbl[0]  = mk(0, 1, 8'h01, 0,   1, 0, 8'h00, 0);
    tbl[1]  = mk(0, 1, 8'h02, 0,   1, 0, 8'h00, 1);
    tbl[2]  = mk(0, 1, 8'h03, 0,   1, 0, 8'h00, 2);
    tbl[3]  = mk(0, 1, 8'h04, 0,   1, 1, 8'h01, 3);
    tbl[4]  = mk(0, 1, 8'h05, 0,   1, 1, 8'h01, 4);
    tbl[5]  = mk(0, 1, 8'h06, 0,   1, 1, 8'h01, 5);
    tbl[6]  = mk(0, 1, 8'h07, 0,   0, 1, 8'h01, 6);
    tbl[7]  = mk(0, 1, 8'h07, 0,   0, 1, 8'h01, 6);
    tbl[8]  = mk(0, 0, 8'h00, 1,   0, 1, 8'h01, 6);
    tbl[9]  = mk(0, 0, 8'h00, 1,   0, 1, 8'h02, 5);
    tbl[10] = mk(0, 0, 8'h00, 1,   0, 1, 8'h03, 4);
    tbl[11] = mk(0, 0, 8'h00, 1,   1, 1, 8'h04, 3);
    tbl[12] = mk(0, 0, 8'h00, 1,   1, 1, 8'h05, 2);
    tbl[13] = mk(0, 0, 8'h00, 1,   1, 1, 8'h06, 1);
    tbl[14] = mk(0, 0, 8'h00, 1,   1, 0, 8'h06, 0);
    tbl[15] = mk(0, 1, 8'h11, 0,   1, 0, 8'h06, 0);
    tbl[16] = mk(0, 1, 8'h12, 0,   1, 0, 8'h06, 1);
    tbl[17] = mk(0, 1, 8'h13, 0,   1, 0, 8'h06, 2);
    tbl[18] = mk(0, 1, 8'h14, 0,   1, 1, 8'h11, 3);
    tbl[19] = mk(0, 1, 8'h15, 0,   1, 1, 8'h11, 4);
    tbl[20] = mk(0, 1, 8'h16, 0,   1, 1, 8'h11, 5);
    tbl[21] = mk(1, 1, 8'h17, 1,   0, 0, 8'h11, 6);
    tbl[22] = mk(0, 1, 8'hAA, 1,   1, 0, 8'h11, 0);
    tbl[23] = mk(0, 0, 8'h00, 1,   1, 0, 8'h11, 1);
    tbl[24] = mk(0, 0, 8'h00, 1,   1, 0, 8'h11, 1);
    tbl[25] = mk(0, 0, 8'h00, 1,   1, 1, 8'hAA, 1);
    tbl[26] = mk(0, 0, 8'h00, 1,   1, 0, 8'hAA, 0);

    clk   = 0;
    rst_n = 0;
    idle_all();
    #12;
    chk("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_occ",       32'(bus_a.occupancy), 32'd0);
    chk("rst_out_data",  32'(bus_a.out_data),  32'd0);
    chk("rst_b_in_ready", 32'(bus_b.in_ready), 32'd1);
    chk("rst_c_out_valid", 32'(bus_c.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Table: backpressure fill/drain and flush-while-full.
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      bus_a.flush     = tbl[i].fl;
      bus_a.in_valid  = tbl[i].iv;
      bus_a.in_data   = tbl[i].d;
      bus_a.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i),  32'(bus_a.in_ready),  32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus_a.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i),  32'(bus_a.out_data),  32'(tbl[i].e_od));
      chk($sformatf("tbl%0d_occ", i),       32'(bus_a.occupancy), 32'(tbl[i].e_occ));
    end

    // Streaming 0x01..0x10 with out_ready held high.
    for (int t = 0; t < 22; t++) begin
      @(negedge clk);
      bus_a.flush     = 0;
      bus_a.in_valid  = (t < 16);
      bus_a.in_data   = 8'(t + 1);
      bus_a.out_ready = 1;
      #1;
      exp_occ = (t < 3) ? t : (t < 16) ? 3 : (t < 19) ? 19 - t : 0;
      chk($sformatf("str%0d_in_ready", t),  32'(bus_a.in_ready),  32'd1);
      chk($sformatf("str%0d_out_valid", t), 32'(bus_a.out_valid), 32'((t >= 3) && (t < 19)));
      if (bus_a.out_valid)
        chk($sformatf("str%0d_out_data", t), 32'(bus_a.out_data), 32'(t - 2));
      chk($sformatf("str%0d_occ", t), 32'(bus_a.occupancy), 32'(exp_occ));
    end

    // Asynchronous reset in the middle of a stream.
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      bus_a.in_valid = 1;
      bus_a.in_data  = 8'(8'h40 + t);
    end
    @(posedge clk);
    #3;
    rst_n = 0;
    bus_a.in_valid = 0;
    #1;
    chk("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("arst_occ",       32'(bus_a.occupancy), 32'd0);
    chk("arst_out_data",  32'(bus_a.out_data),  32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("arst_rel_in_ready",  32'(bus_a.in_ready),  32'd1);
    chk("arst_rel_out_valid", 32'(bus_a.out_valid), 32'd0);
    idle_all();

    // Depth-1: latency 1, capacity 2.
    @(negedge clk);
    bus_c.in_valid = 1; bus_c.in_data = 8'h01; bus_c.out_ready = 0;
    #1;
    chk("d1_c0_in_ready",  32'(bus_c.in_ready),  32'd1);
    chk("d1_c0_out_valid", 32'(bus_c.out_valid), 32'd0);
    @(negedge clk);
    bus_c.in_data = 8'h02;
    #1;
    chk("d1_c1_out_valid", 32'(bus_c.out_valid), 32'd1);
    chk("d1_c1_out_data",  32'(bus_c.out_data),  32'h01);
    chk("d1_c1_in_ready",  32'(bus_c.in_ready),  32'd1);
    @(negedge clk);
    bus_c.in_data = 8'h03;
    #1;
    chk("d1_c2_in_ready", 32'(bus_c.in_ready),  32'd0);
    chk("d1_c2_occ",      32'(bus_c.occupancy), 32'd2);
    q_c.push_back(8'h01);
    q_c.push_back(8'h02);
    nxt = 8'h03;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      bus_c.in_valid  = 1;
      bus_c.in_data   = nxt;
      bus_c.out_ready = (t % 2 == 0);
      #1;
      chk($sformatf("d1_%0d_occ", t), 32'(bus_c.occupancy), 32'(q_c.size()));
      chk($sformatf("d1_%0d_occ_max", t), 32'(bus_c.occupancy <= 2'd2), 32'd1);
      if (bus_c.out_valid && bus_c.out_ready) begin
        if (q_c.size() == 0) chk($sformatf("d1_%0d_spurious", t), 32'(bus_c.out_valid), 32'd0);
        else chk($sformatf("d1_%0d_data", t), 32'(bus_c.out_data), 32'(q_c.pop_front()));
      end
      if (bus_c.in_valid && bus_c.in_ready) begin
        q_c.push_back(nxt);
        nxt = nxt + 8'd1;
      end
    end
    idle_all();

    // Random stall with scoreboard, WIDTH=32, NUM_STAGES=5.
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      bus_b.in_valid  = 1'($urandom_range(0, 1));
      bus_b.in_data   = $urandom;
      bus_b.out_ready = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rnd%0d_occ", t), 32'(bus_b.occupancy), 32'(q_b.size()));
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (q_b.size() == 0) chk($sformatf("rnd%0d_spurious", t), 32'(bus_b.out_valid), 32'd0);
        else chk($sformatf("rnd%0d_data", t), bus_b.out_data, q_b.pop_front());
      end
      if (bus_b.in_valid && bus_b.in_ready) q_b.push_back(bus_b.in_data);
    end
    idle_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised elastic datapath pipeline: a chain of `NUM_STAGES` register stages carrying `WIDTH`-bit words with a valid/ready handshake on both ends. It generalises the fixed three-stage 8-bit chain to arbitrary width and depth, and adds three things that chain lacks:

- backpressure tolerance, with full throughput and no combinational ready path;
- a synchronous flush;
- an occupancy count.

It sits between any producer/consumer pair in the datapath.

## Interface

Parameters:
- `WIDTH`, 8, data word width in bits (≥1).
- `NUM_STAGES`, 3, number of chained stages (≥1); total capacity is `2*NUM_STAGES` words.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear of all stored words.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  pipeline can accept a word.
- `in_data`  in  WIDTH  upstream word.
- `out_valid`  out  1  downstream word valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  downstream word.
- `occupancy`  out  `$clog2(2*NUM_STAGES+1)`  words currently held.

## Operation

- **Fire events.**
  - in-fire = `in_valid & in_ready`.
  - out-fire = `out_valid & out_ready`.
- **Stage structure.** Each stage is a skid buffer with two state slots:
  - *main*: `m_valid`, `m_data`;
  - *skid*: `s_valid`, `s_data`.
  - Stage output = main. Stage ready toward upstream = `~s_valid`, a registered value.
- **Per-stage transitions** (up-fire into stage, dn-fire out of stage):
  - Main empty, up-fire: word goes to main.
  - Main full, dn-fire, up-fire: the new word replaces main.
  - Main full, no dn-fire, up-fire: the new word goes to skid; ready drops next cycle.
  - Skid full, dn-fire: skid moves to main and skid clears.
- **Ordering.** Words leave in strict arrival order; none are dropped or duplicated except by flush.
- **Flush.**
  - In the cycle `flush=1`, `in_ready` and `out_valid` are forced to 0 (no fires occur).
  - At the following edge all `m_valid`/`s_valid` clear and `occupancy` becomes 0.
  - Data registers keep their values.
  - Flush takes priority over any handshake in the same cycle.
- **Occupancy.**
  - +1 on in-fire, −1 on out-fire; unchanged when both or neither occur.
  - Never exceeds `2*NUM_STAGES` and never underflows.
- **Reset values.**
  - All valid bits, data registers, `out_data` and `occupancy` are 0.
  - `out_valid` is 0.
  - `in_ready` is 1 (all skids empty). Upstream holds `in_valid` low while `rst_n` is low.
- **Reset mid-operation.** Asserting `rst_n` discards all contents immediately (asynchronous); outputs take their reset values in the same cycle.

## Timing

- **Latency.** In an empty pipe with `out_ready=1`, a word in-fired in cycle c gives `out_valid=1` with that word in cycle c+`NUM_STAGES`.
- **Throughput.** One word per cycle sustained while `out_ready=1`.
- **No combinational paths** from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`. The only combinational input dependence of the handshake outputs is the `flush` masking.
- **Stall propagation.** After `out_ready` falls, `in_ready` falls no earlier than `NUM_STAGES` cycles later, and only once all skids have filled. At full capacity `in_ready=0` until an out-fire. `in_ready` rises the cycle after the stage-0 skid drains.
- **Stability.** While `out_valid & ~out_ready`, `out_data` is held stable.
- **Simultaneous fires.** In-fire and out-fire in the same cycle at full capacity cannot occur (`in_ready=0`). At capacity−1 both are legal, and `occupancy` stays unchanged.

## Structure

- **Package `elastic_pipe_pkg`:**
  - `function automatic int occ_width(int stages)` returning `$clog2(2*stages+1)`;
  - localparam `CAPACITY_PER_STAGE = 2`.
- **Sub-module `skid_stage`** (`WIDTH` parameter; `clk`, `rst_n`, `flush`, up/down valid/ready/data). It is instantiated `NUM_STAGES` times in a generate loop.
- The top level holds the stage chain, the flush masking and the occupancy counter.

## Test plan

- **Streaming:** `WIDTH=8`, `NUM_STAGES=3`, `out_ready=1`, push 0x01..0x10 back-to-back → first `out_valid` 3 cycles after first fire, then 0x01..0x10 in order on consecutive cycles, `occupancy` steady at 3.
- **Full backpressure:** `out_ready=0`, push continuously → exactly 6 words accepted, `in_ready=0`, `occupancy=6`. Raise `out_ready` → 6 words out in order; `in_ready` returns and no word is lost.
- **Random stall:** random `in_valid`/`out_ready` (50%) for 2000 cycles, `WIDTH=32`, `NUM_STAGES=5` → scoreboard order matches, and `occupancy` equals (in-fires − out-fires) every cycle.
- **Flush while full:** `NUM_STAGES=3`, fill to 6, assert `flush` one cycle with `in_valid=1` → no fire in that cycle, `occupancy=0` and `out_valid=0` next cycle. The next pushed word 0xAA emerges first.
- **Async reset mid-stream:** pulse `rst_n` low mid-cycle during streaming → `out_valid=0`, `occupancy=0`, `out_data=0` immediately, `in_ready=1` after release.
- **Depth-1 edge:** `NUM_STAGES=1`, alternate `out_ready` 1/0 → latency 1, capacity 2, `occupancy` never exceeds 2.
